branch_predict_unit: RTL and testbench
======================================

// Module: branch_predict_unit
// PURPOSE
//  Direct-mapped BTB + per-entry 2-bit saturating direction counters. Supplies btb_hit,
//  predict_taken and btb_pre_pc to the next-PC select mux in the same cycle as the fetch PC.
//  Trained from the execute stage with resolved branch/jump outcomes.
//  Counts execute-stage redirects (addr/branch fix) for performance monitoring.
// PARAMETERS
//  BTB_ENTRIES  16  number of entries, power of two, >=2
//  IDX_W        4   log2(BTB_ENTRIES)
//  TAG_W        26  32-IDX_W-2; stored tag width, PC[31:IDX_W+2]
//  CNT_W        32  width of the perf counters, saturating
// PORTS
//  clk               in   1      core clock, rising edge
//  rst_n             in   1      asynchronous, active-low reset
//  fetch_pc_i        in   32     PC being fetched this cycle
//  btb_hit_o         out  1      valid entry whose tag matches fetch_pc_i
//  predict_taken_o   out  1      btb_hit_o & counter MSB
//  btb_pre_pc_o      out  32     stored target of the indexed entry
//  ex_valid_i        in   1      execute-stage instruction valid, not squashed
//  ex_is_branch_i    in   1      conditional branch in execute
//  ex_is_jump_i      in   1      unconditional jump (jal/jalr) in execute
//  ex_pc_i           in   32     PC of the execute instruction
//  ex_target_i       in   32     resolved target address
//  ex_taken_i        in   1      resolved direction; ignored for jumps, which are taken
//  ex_redirect_i     in   1      execute addr_fix | branch_fix this cycle
//  branch_cnt_o      out  CNT_W  trained branches/jumps since reset
//  redirect_cnt_o    out  CNT_W  redirects since reset
// BEHAVIOUR
//  - Index is PC[IDX_W+1:2]. Tag is PC[31:IDX_W+2]. PC[1:0] is ignored.
//  - Lookup is combinational with zero latency. It reads registered table state only.
//  - Update: upd = ex_valid_i & (ex_is_branch_i | ex_is_jump_i). It writes at the clk edge.
//    - Miss (invalid or tag mismatch) and taken: allocate/replace the entry.
//      valid=1, tag, target=ex_target_i. ctr=2'b11 for a jump, 2'b10 for a branch.
//    - Miss and not taken: no write. Do not allocate on a not-taken branch.
//    - Hit and jump: ctr=2'b11, target=ex_target_i.
//    - Hit and branch taken: ctr=sat_inc(ctr), target=ex_target_i.
//    - Hit and branch not taken: ctr=sat_dec(ctr). Target unchanged.
//  - Saturation: ctr stays at 11 on increment and at 00 on decrement.
//  - Both ex_is_branch_i and ex_is_jump_i set: treat as a jump.
//  - Same-index lookup and update in one cycle: the lookup returns the pre-update contents.
//    There is no write-through bypass.
//  - Aliasing: a tag mismatch on update replaces the whole entry.
//  - Counters:
//    - branch_cnt_o increments by 1 on each upd.
//    - redirect_cnt_o increments by 1 on each ex_redirect_i, independent of upd.
//    - Both hold at all-ones.
//  - Reset values, applied asynchronously including mid-operation:
//    - Table: all valid=0, ctr=2'b01, target=0, tag=0.
//    - Outputs: btb_hit_o=0, predict_taken_o=0, btb_pre_pc_o=0.
//    - Perf counters: 0.
//    - First update allowed on the first clk edge after rst_n deasserts.
// STRUCTURE
//  - define.v holds:
//    - `BTB_ENTRIES and `BTB_IDX_W defaults.
//    - Counter encodings `CTR_SNT=2'b00, `CTR_WNT=2'b01, `CTR_WT=2'b10, `CTR_ST=2'b11.
//  - One sub-module, sat_cnt2: combinational 2-bit saturating next-state from (ctr, inc).
//  - Table: flop arrays valid/tag/target/ctr. No SRAM, because the lookup is asynchronous.
// TESTING
//  - Reset, then fetch_pc_i=0x8000_0000.
//    -> btb_hit_o=0, predict_taken_o=0, btb_pre_pc_o=0, both counters 0.
//  - Taken branch, ex_pc_i=0x8000_0010, target=0x8000_0100. Next cycle fetch 0x8000_0010.
//    -> hit=1, taken=1, pre_pc=0x8000_0100, branch_cnt_o=1.
//  - Same branch not taken twice: ctr 10->01->00 -> hit=1, taken=0.
//    Then three taken updates -> ctr 11, and a further taken update stays 11.
//  - Not-taken branch at 0x8000_0020 with an empty entry.
//    -> no allocation; a later lookup gives hit=0.
//  - Jump at 0x8000_0010, then alias 0x8000_0050 (same index) jumps to 0x8000_0200.
//    -> 0x8000_0010 misses; 0x8000_0050 hits with target 0x8000_0200, taken=1.
//  - Update and lookup on the same index in one cycle -> old data returned that cycle.
//    Assert rst_n low mid-stream -> all outputs 0 immediately.
//    Assert ex_redirect_i for 5 cycles -> redirect_cnt_o=5.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Shared sizing defaults and 2-bit direction counter encodings for the branch predictor.
package branch_predict_unit_pkg;
   localparam int BPU_ENTRIES_DEF = 16;
   localparam int BPU_IDX_W_DEF   = 4;
   localparam int BPU_CNT_W_DEF   = 32;

   typedef logic [1:0] ctr_t;

   localparam ctr_t CTR_SNT = 2'b00;
   localparam ctr_t CTR_WNT = 2'b01;
   localparam ctr_t CTR_WT  = 2'b10;
   localparam ctr_t CTR_ST  = 2'b11;
endpackage

// File: rtl/branch_predict_unit_sat_cnt2.sv
// 2-bit saturating direction counter next-state, purely combinational.
module sat_cnt2
   import branch_predict_unit_pkg::*;
(
   input  ctr_t ctr_i,
   input  logic inc_i,
   output ctr_t ctr_o
);
   always_comb begin
      ctr_o = ctr_i;
      if (inc_i) begin
         if (ctr_i != CTR_ST) ctr_o = ctr_i + 2'b01;
      end else begin
         if (ctr_i != CTR_SNT) ctr_o = ctr_i - 2'b01;
      end
   end
endmodule

// File: rtl/branch_predict_unit.sv
// Direct-mapped BTB with 2-bit direction counters; zero-latency lookup from registered state,
// trained at the clock edge by execute-stage outcomes; saturating perf counters.
module branch_predict_unit
   import branch_predict_unit_pkg::*;
#(
   parameter int BTB_ENTRIES = BPU_ENTRIES_DEF,
   parameter int IDX_W       = BPU_IDX_W_DEF,
   parameter int TAG_W       = 32 - IDX_W - 2,
   parameter int CNT_W       = BPU_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      fetch_pc_i,
   output logic             btb_hit_o,
   output logic             predict_taken_o,
   output logic [31:0]      btb_pre_pc_o,
   input  logic             ex_valid_i,
   input  logic             ex_is_branch_i,
   input  logic             ex_is_jump_i,
   input  logic [31:0]      ex_pc_i,
   input  logic [31:0]      ex_target_i,
   input  logic             ex_taken_i,
   input  logic             ex_redirect_i,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] redirect_cnt_o
);
   logic             valid_q  [BTB_ENTRIES];
   logic [TAG_W-1:0] tag_q    [BTB_ENTRIES];
   logic [31:0]      target_q [BTB_ENTRIES];
   ctr_t             ctr_q    [BTB_ENTRIES];

   logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
   logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

   logic [IDX_W-1:0] f_idx, e_idx;
   logic [TAG_W-1:0] f_tag, e_tag;
   logic             upd, ex_taken_eff, ex_hit, wr_en;
   ctr_t             sat_ctr, wr_ctr;
   logic [31:0]      wr_tgt;
   logic             unused_pc_lsbs;

   assign unused_pc_lsbs = ^{fetch_pc_i[1:0], ex_pc_i[1:0]};

   assign f_idx = fetch_pc_i[IDX_W+1:2];
   assign f_tag = fetch_pc_i[31:IDX_W+2];
   assign e_idx = ex_pc_i[IDX_W+1:2];
   assign e_tag = ex_pc_i[31:IDX_W+2];

   // No bypass from the update path: a same-index lookup sees pre-update contents.
   assign btb_hit_o       = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
   assign predict_taken_o = btb_hit_o && ctr_q[f_idx][1];
   assign btb_pre_pc_o    = target_q[f_idx];

   assign upd          = ex_valid_i && (ex_is_branch_i || ex_is_jump_i);
   assign ex_taken_eff = ex_is_jump_i || ex_taken_i;
   assign ex_hit       = valid_q[e_idx] && (tag_q[e_idx] == e_tag);

   sat_cnt2 u_sat_cnt2 (
      .ctr_i (ctr_q[e_idx]),
      .inc_i (ex_taken_i),
      .ctr_o (sat_ctr)
   );

   always_comb begin
      wr_en  = 1'b0;
      wr_ctr = ctr_q[e_idx];
      wr_tgt = target_q[e_idx];
      if (upd) begin
         if (!ex_hit) begin
            // Never allocate on a not-taken branch; a taken miss replaces the whole entry.
            wr_en  = ex_taken_eff;
            wr_ctr = ex_is_jump_i ? CTR_ST : CTR_WT;
            wr_tgt = ex_target_i;
         end else if (ex_is_jump_i) begin
            wr_en  = 1'b1;
            wr_ctr = CTR_ST;
            wr_tgt = ex_target_i;
         end else begin
            wr_en  = 1'b1;
            wr_ctr = sat_ctr;
            if (ex_taken_i) wr_tgt = ex_target_i;
         end
      end
   end

   always_comb begin
      branch_cnt_d   = branch_cnt_q;
      redirect_cnt_d = redirect_cnt_q;
      if (upd && (branch_cnt_q != '1))            branch_cnt_d   = branch_cnt_q + 1'b1;
      if (ex_redirect_i && (redirect_cnt_q != '1)) redirect_cnt_d = redirect_cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BTB_ENTRIES; i++) begin
            valid_q[i]  <= 1'b0;
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= CTR_WNT;
         end
         branch_cnt_q   <= '0;
         redirect_cnt_q <= '0;
      end else begin
         if (wr_en) begin
            valid_q[e_idx]  <= 1'b1;
            tag_q[e_idx]    <= e_tag;
            target_q[e_idx] <= wr_tgt;
            ctr_q[e_idx]    <= wr_ctr;
         end
         branch_cnt_q   <= branch_cnt_d;
         redirect_cnt_q <= redirect_cnt_d;
      end
   end

   assign branch_cnt_o   = branch_cnt_q;
   assign redirect_cnt_o = redirect_cnt_q;
endmodule

// File: tb/tb_branch_predict_unit.sv
// Scoreboard bench for branch_predict_unit: each cycle's expected lookup/counter view is queued
// when stimulus is driven and popped at the following negedge.
module tb_branch_predict_unit;
   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fetch_pc;
   logic        btb_hit, predict_taken;
   logic [31:0] btb_pre_pc;
   logic        ex_valid, ex_is_branch, ex_is_jump, ex_taken, ex_redirect;
   logic [31:0] ex_pc, ex_target;
   logic [31:0] branch_cnt, redirect_cnt;

   always #5 clk = ~clk;

   branch_predict_unit dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .fetch_pc_i      (fetch_pc),
      .btb_hit_o       (btb_hit),
      .predict_taken_o (predict_taken),
      .btb_pre_pc_o    (btb_pre_pc),
      .ex_valid_i      (ex_valid),
      .ex_is_branch_i  (ex_is_branch),
      .ex_is_jump_i    (ex_is_jump),
      .ex_pc_i         (ex_pc),
      .ex_target_i     (ex_target),
      .ex_taken_i      (ex_taken),
      .ex_redirect_i   (ex_redirect),
      .branch_cnt_o    (branch_cnt),
      .redirect_cnt_o  (redirect_cnt)
   );

   typedef struct packed {
      logic        hit;
      logic        tk;
      logic [31:0] pc;
      logic [31:0] bc;
      logic [31:0] rc;
   } exp_t;

   exp_t sb_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   int   step   = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input logic h, input logic t, input logic [31:0] p,
                               input logic [31:0] b, input logic [31:0] r);
      exp_t e;
      e.hit = h; e.tk = t; e.pc = p; e.bc = b; e.rc = r;
      return e;
   endfunction

   // One cycle: drive after the edge, compare the lookup view at the negedge, commit at next edge.
   task automatic cyc(input logic [31:0] fpc, input logic v, input logic br, input logic jp,
                      input logic [31:0] epc, input logic [31:0] tgt, input logic tk,
                      input logic rd, input exp_t e);
      exp_t x;
      @(posedge clk);
      #1;
      fetch_pc = fpc; ex_valid = v; ex_is_branch = br; ex_is_jump = jp;
      ex_pc = epc; ex_target = tgt; ex_taken = tk; ex_redirect = rd;
      sb_q.push_back(e);
      @(negedge clk);
      step++;
      if (sb_q.size() == 0) begin
         n_chk++; n_fail++;
         $display("FAIL s%0d_scoreboard: queue empty", step);
      end else begin
         x = sb_q.pop_front();
         check_eq($sformatf("s%0d_hit", step),          {31'd0, btb_hit},       {31'd0, x.hit});
         check_eq($sformatf("s%0d_taken", step),        {31'd0, predict_taken}, {31'd0, x.tk});
         check_eq($sformatf("s%0d_pre_pc", step),       btb_pre_pc,             x.pc);
         check_eq($sformatf("s%0d_branch_cnt", step),   branch_cnt,             x.bc);
         check_eq($sformatf("s%0d_redirect_cnt", step), redirect_cnt,           x.rc);
      end
   endtask

   localparam logic [31:0] PA = 32'h8000_0010;
   localparam logic [31:0] PB = 32'h8000_0020;
   localparam logic [31:0] PC = 32'h8000_0050;
   localparam logic [31:0] TA = 32'h8000_0100;
   localparam logic [31:0] TJ = 32'h8000_0300;
   localparam logic [31:0] TC = 32'h8000_0200;

   initial begin
      rst_n = 1'b0;
      fetch_pc = 32'h8000_0000; ex_valid = 0; ex_is_branch = 0; ex_is_jump = 0;
      ex_pc = 0; ex_target = 0; ex_taken = 0; ex_redirect = 0;
      #23 rst_n = 1'b1;

      cyc(32'h8000_0000, 0,0,0, 0, 0, 0, 0, mk(0,0,0,0,0));
      // Taken branch allocates; same-index lookup that cycle still sees the empty entry.
      cyc(PA, 1,1,0, PA, TA, 1, 0, mk(0,0,0,0,0));
      cyc(PA, 1,1,0, PA, TA, 0, 0, mk(1,1,TA,1,0));   // ctr 10 -> 01
      cyc(PA, 1,1,0, PA, TA, 0, 0, mk(1,0,TA,2,0));   // 01 -> 00
      cyc(PA, 1,1,0, PA, TA, 1, 0, mk(1,0,TA,3,0));   // 00 -> 01
      cyc(PA, 1,1,0, PA, TA, 1, 0, mk(1,0,TA,4,0));   // 01 -> 10
      cyc(PA, 1,1,0, PA, TA, 1, 0, mk(1,1,TA,5,0));   // 10 -> 11
      cyc(PA, 1,1,0, PA, TA, 1, 0, mk(1,1,TA,6,0));   // 11 stays 11
      cyc(PA, 1,1,0, PA, TA, 0, 0, mk(1,1,TA,7,0));   // 11 -> 10
      cyc(PA, 1,1,0, PA, TA, 0, 0, mk(1,1,TA,8,0));   // 10 -> 01
      cyc(PA, 0,0,0, 0, 0, 0, 0, mk(1,0,TA,9,0));
      // Not-taken branch to an empty entry must not allocate.
      cyc(PB, 1,1,0, PB, TC, 0, 0, mk(0,0,0,9,0));
      cyc(PB, 0,0,0, 0, 0, 0, 0, mk(0,0,0,10,0));
      // Jump on hit forces ctr 11 and a new target.
      cyc(PA, 1,0,1, PA, TJ, 0, 0, mk(1,0,TA,10,0));
      // Alias with both branch and jump set, taken=0: treated as a jump, replaces the entry.
      cyc(PA, 1,1,1, PC, TC, 0, 0, mk(1,1,TJ,11,0));
      cyc(PA, 0,0,0, 0, 0, 0, 0, mk(0,0,TC,12,0));
      cyc(PC, 0,0,0, 0, 0, 0, 0, mk(1,1,TC,12,0));
      for (int i = 0; i < 5; i++)
         cyc(PC, 0,0,0, 0, 0, 0, 1, mk(1,1,TC,12,i));
      // Squashed taken branch: no train, no count.
      cyc(PC, 0,1,0, PB, TA, 1, 0, mk(1,1,TC,12,5));
      cyc(PB, 0,0,0, 0, 0, 0, 0, mk(0,0,0,12,5));

      // Mid-stream asynchronous reset while an update and a redirect are being driven.
      @(posedge clk); #1;
      fetch_pc = PC; ex_valid = 1; ex_is_branch = 0; ex_is_jump = 1;
      ex_pc = PC; ex_target = TA; ex_redirect = 1;
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_hit",          {31'd0, btb_hit},       32'd0);
      check_eq("rst_taken",        {31'd0, predict_taken}, 32'd0);
      check_eq("rst_pre_pc",       btb_pre_pc,             32'd0);
      check_eq("rst_branch_cnt",   branch_cnt,             32'd0);
      check_eq("rst_redirect_cnt", redirect_cnt,           32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ex_valid = 0; ex_is_jump = 0; ex_redirect = 0;
      cyc(PC, 0,0,0, 0, 0, 0, 0, mk(0,0,0,0,0));

      if (sb_q.size() != 0) begin
         n_chk++; n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL watchdog: timeout at %0t, expected completion", $time);
      $fatal(1, "timeout");
   end
endmodule
